// File: rtl/rails_chain.sv
// Multi-station railway stack-reorganisation checker: loads n and one departure order per
// station, then simulates each station's stack one operation per cycle. Optional macro RAILS_CHAIN_PERM_CHECK_EN.
module rails_chain #(
    parameter int  MAX_N  = 15,
    parameter int  STAGES = 2,
    parameter int  DEPTH  = 6,
    localparam int W      = $clog2(MAX_N + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [W-1:0]        number,
    input  logic                in_valid,
    input  logic [STAGES*W-1:0] data,
    output logic                ready,
    output logic                valid,
    output logic [STAGES-1:0]   result,
    output logic [STAGES-1:0]   err
);
    localparam int KW  = (STAGES > 1) ? $clog2(STAGES) : 1;
    localparam int SPW = $clog2(DEPTH + 1);
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OAW = (MAX_N > 1) ? $clog2(MAX_N) : 1;
    localparam logic [W-1:0]   MAX_V   = W'(MAX_N);
    localparam logic [SPW-1:0] DEPTH_V = SPW'(DEPTH);
    localparam logic [KW-1:0]  LAST_K  = KW'(STAGES - 1);

    typedef enum logic [2:0] {IDLE, LOAD, INIT, STEP, DONE} state_t;

    state_t            state_reg;
    logic [W-1:0]      n_reg, idx_reg, arr_reg;
    logic [SPW-1:0]    sp_reg;
    logic [KW-1:0]     k_reg, k_prev;
    logic              ready_reg, valid_reg;
    logic [STAGES-1:0] result_reg, err_vec;

    logic [W-1:0] order_mem [STAGES][MAX_N];
    logic [W-1:0] stack_mem [STAGES][DEPTH];

    logic [W-1:0] top_val, want_val, arrival_val;
    logic         do_pass, do_pop, do_push, accept;

    assign k_prev = k_reg - 1'b1;
    assign accept = (state_reg == IDLE) && ready_reg && start;

    always_comb begin
        top_val     = stack_mem[k_reg][AW'(sp_reg - 1'b1)];
        want_val    = order_mem[k_reg][OAW'(idx_reg)];
        arrival_val = (k_reg == '0) ? (arr_reg + 1'b1) : order_mem[k_prev][OAW'(arr_reg)];
    end

    // One action per STEP cycle, in priority order: pass, pop, push, else fail.
    assign do_pass = (idx_reg == n_reg);
    assign do_pop  = !do_pass && (sp_reg != '0) && (top_val == want_val);
    assign do_push = !do_pass && !do_pop && (arr_reg < n_reg) && (sp_reg < DEPTH_V);

    always_ff @(posedge clk) begin
        if (state_reg == LOAD && in_valid) begin
            for (int s = 0; s < STAGES; s++)
                order_mem[s][OAW'(idx_reg)] <= data[s*W +: W];
        end
        if (state_reg == STEP && do_push)
            stack_mem[k_reg][AW'(sp_reg)] <= arrival_val;
    end

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
`ifdef RAILS_CHAIN_PERM_CHECK_EN
        logic [MAX_N-1:0] seen_reg;
        logic             err_bit;
        logic [W-1:0]     beat;
        assign beat        = data[gi*W +: W];
        assign err_vec[gi] = err_bit;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                seen_reg <= '0;
                err_bit  <= 1'b0;
            end else if (accept) begin
                seen_reg <= '0;
                err_bit  <= 1'b0;
            end else if (state_reg == LOAD && in_valid) begin
                if (beat == '0 || beat > n_reg || seen_reg[OAW'(beat - 1'b1)])
                    err_bit <= 1'b1;
                else
                    seen_reg[OAW'(beat - 1'b1)] <= 1'b1;
            end
        end
`else
        assign err_vec[gi] = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            ready_reg  <= 1'b0;
            valid_reg  <= 1'b0;
            result_reg <= '0;
            n_reg      <= '0;
            idx_reg    <= '0;
            arr_reg    <= '0;
            sp_reg     <= '0;
            k_reg      <= '0;
        end else begin
            valid_reg <= 1'b0;
            ready_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    ready_reg <= 1'b1;
                    if (accept) begin
                        ready_reg <= 1'b0;
                        n_reg     <= (number > MAX_V) ? MAX_V : number;
                        idx_reg   <= '0;
                        if (number == '0) begin
                            result_reg <= '1;
                            state_reg  <= DONE;
                        end else begin
                            result_reg <= '0;
                            state_reg  <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        idx_reg <= idx_reg + 1'b1;
                        if (idx_reg == n_reg - 1'b1) begin
                            k_reg     <= '0;
                            state_reg <= INIT;
                        end
                    end
                end
                INIT: begin
                    sp_reg  <= '0;
                    idx_reg <= '0;
                    arr_reg <= '0;
                    if ((k_reg != '0 && !result_reg[k_prev]) || err_vec[k_reg]) begin
                        result_reg[k_reg] <= 1'b0;
                        if (k_reg == LAST_K)
                            state_reg <= DONE;
                        else
                            k_reg <= k_reg + 1'b1;
                    end else begin
                        state_reg <= STEP;
                    end
                end
                STEP: begin
                    if (do_pass) begin
                        result_reg[k_reg] <= (k_reg == '0) ? 1'b1 : result_reg[k_prev];
                        if (k_reg == LAST_K) begin
                            state_reg <= DONE;
                        end else begin
                            k_reg     <= k_reg + 1'b1;
                            state_reg <= INIT;
                        end
                    end else if (do_pop) begin
                        sp_reg  <= sp_reg - 1'b1;
                        idx_reg <= idx_reg + 1'b1;
                    end else if (do_push) begin
                        sp_reg  <= sp_reg + 1'b1;
                        arr_reg <= arr_reg + 1'b1;
                    end else begin
                        // A stuck station sinks itself and every station downstream.
                        for (int i = 0; i < STAGES; i++)
                            if (i >= int'(k_reg)) result_reg[i] <= 1'b0;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    valid_reg <= 1'b1;
                    ready_reg <= 1'b1;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign ready  = ready_reg;
    assign valid  = valid_reg;
    assign result = result_reg;
    assign err    = err_vec;
endmodule

// File: tb/tb_rails_chain.sv
// Directed bench for rails_chain: a default instance (DEPTH=6) and a small one (MAX_N=12, DEPTH=4)
// share all stimulus; results, error flags and latencies are checked against hand-derived values.
module tb_rails_chain;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [3:0] number = '0;
    logic       in_valid = 1'b0;
    logic [7:0] data = '0;
    logic       ready_a, valid_a, ready_b, valid_b;
    logic [1:0] result_a, err_a, result_b, err_b;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int vcyc_a = 0, vcyc_b = 0, vcount_a = 0, vcount_b = 0;
    int base_a, base_b, start_cyc, beat_a, beat_b;

    always #5 clk = ~clk;

    rails_chain #(.MAX_N(15), .STAGES(2), .DEPTH(6)) u_dut_a (
        .clk(clk), .reset(reset), .start(start), .number(number), .in_valid(in_valid),
        .data(data), .ready(ready_a), .valid(valid_a), .result(result_a), .err(err_a)
    );

    rails_chain #(.MAX_N(12), .STAGES(2), .DEPTH(4)) u_dut_b (
        .clk(clk), .reset(reset), .start(start), .number(number), .in_valid(in_valid),
        .data(data), .ready(ready_b), .valid(valid_b), .result(result_b), .err(err_b)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid_a) begin
            vcyc_a = cyc;
            vcount_a++;
        end
        if (valid_b) begin
            vcyc_b = cyc;
            vcount_b++;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Lists hold element i in nibble i (element 0 in the least significant nibble).
    task automatic load_job(input logic [3:0] num, input logic [59:0] o0, input logic [59:0] o1,
                            input logic [14:0] stall);
        int guard = 0;
        int n_b;
        @(negedge clk);
        while (!(ready_a && ready_b) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("ready_wait", int'(ready_a && ready_b), 1);
        base_a = vcount_a;
        base_b = vcount_b;
        start  = 1'b1;
        number = num;
        @(negedge clk);
        start     = 1'b0;
        start_cyc = cyc;
        n_b       = (num > 4'd12) ? 12 : int'(num);
        for (int i = 0; i < int'(num); i++) begin
            if (stall[i]) @(negedge clk);
            in_valid = 1'b1;
            data     = {o1[i*4 +: 4], o0[i*4 +: 4]};
            @(negedge clk);
            in_valid = 1'b0;
            if (i == int'(num) - 1) beat_a = cyc;
            if (i == n_b - 1) beat_b = cyc;
        end
        in_valid = 1'b0;
    endtask

    task automatic finish_job(input string tag, input logic [1:0] exp_a, input logic [1:0] exp_b,
                              input logic [1:0] exp_e, input int exp_lat_a, input int exp_lat_b,
                              input bit from_start);
        int guard = 0;
        while (!(vcount_a != base_a && vcount_b != base_b) && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        check({tag, "_done"}, int'(vcount_a != base_a && vcount_b != base_b), 1);
        check({tag, "_res_a"}, int'(result_a), int'(exp_a));
        check({tag, "_res_b"}, int'(result_b), int'(exp_b));
        check({tag, "_err_a"}, int'(err_a), int'(exp_e));
        check({tag, "_err_b"}, int'(err_b), int'(exp_e));
        check({tag, "_lat_a"}, vcyc_a - (from_start ? start_cyc : beat_a), exp_lat_a);
        check({tag, "_lat_b"}, vcyc_b - (from_start ? start_cyc : beat_b), exp_lat_b);
        check({tag, "_pulse_a"}, vcount_a - base_a, 1);
        check({tag, "_ready_a"}, int'(ready_a), 1);
        $display("[TB] job %s: result_a=%b result_b=%b err_a=%b lat_a=%0d lat_b=%0d",
                 tag, result_a, result_b, err_a, vcyc_a - (from_start ? start_cyc : beat_a),
                 vcyc_b - (from_start ? start_cyc : beat_b));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_ready", int'(ready_a), 0);
        check("rst_valid", int'(valid_a), 0);
        check("rst_result", int'(result_a), 0);
        check("rst_err", int'(err_a), 0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready_a", int'(ready_a), 1);
        check("post_rst_ready_b", int'(ready_b), 1);

        // Reverse then identity: passes with DEPTH 6; DEPTH 4 fills at top 4 while waiting for 5.
        load_job(4'd5, 60'h12345, 60'h54321, 15'h0);
        finish_job("rev_id", 2'b11, 2'b00, 2'b00, 25, 7, 1'b0);

        // Identity then 3,1,2,4,5: station 1 infeasible.
        load_job(4'd5, 60'h54321, 60'h54213, 15'h0);
        finish_job("id_312", 2'b01, 2'b01, 2'b00, 21, 21, 1'b0);

        // Empty job: straight to DONE, valid on the second edge counting the one sampling start.
        load_job(4'd0, 60'h0, 60'h0, 15'h0);
        finish_job("n0", 2'b11, 2'b11, 2'b00, 1, 1, 1'b1);

        // n=15: small instance saturates to 12 cars.
        load_job(4'd15, 60'hFEDCBA987654321, 60'hFEDCBA987654321, 15'h0);
        finish_job("n15_sat", 2'b11, 2'b11, 2'b00, 65, 53, 1'b0);

        // Reset in station-1 STEP aborts the job with no valid.
        load_job(4'd5, 60'h12345, 60'h54321, 15'h0);
        repeat (18) @(negedge clk);
        check("mid_result", int'(result_a), 1);
        base_a = vcount_a;
        reset  = 1'b1;
        #1;
        check("abort_valid", int'(valid_a), 0);
        check("abort_result", int'(result_a), 0);
        check("abort_err", int'(err_a), 0);
        check("abort_ready", int'(ready_a), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort_ready_after", int'(ready_a), 1);
        repeat (30) @(negedge clk);
        check("abort_no_valid", vcount_a - base_a, 0);

        // Same infeasible job as before, with in_valid stalls during LOAD.
        load_job(4'd5, 60'h54321, 60'h54213, 15'b000_0000_0000_1010);
        finish_job("stall", 2'b01, 2'b01, 2'b00, 21, 21, 1'b0);

        // Repeated value in order 1.
`ifdef RAILS_CHAIN_PERM_CHECK_EN
        load_job(4'd5, 60'h54321, 60'h54322, 15'h0);
        finish_job("dup", 2'b01, 2'b01, 2'b10, 14, 14, 1'b0);
`else
        load_job(4'd5, 60'h54321, 60'h54322, 15'h0);
        finish_job("dup", 2'b01, 2'b01, 2'b00, 21, 21, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
